// File: rtl/fetch_pkg.sv
// ----------------------------------------------------------------------------
// fetch_pkg
//   Shared types and constants for the instruction fetch front end.
//   - fetch_entry_t    : {pc, inst} pair held in the instruction queue
//   - DEFAULT_RESET_PC : first PC fetched after reset
// ----------------------------------------------------------------------------
package fetch_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h1eceb000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// ----------------------------------------------------------------------------
// fetch_queue
//   Synchronous FIFO of fetch_entry_t used as the fetch -> decode buffer.
//   Ports:
//     clk, rst   clock, synchronous active-high reset
//     flush      discard all entries this edge (overrides enq/deq)
//     enq        push enq_data at the edge
//     enq_data   entry to push
//     deq        pop the head at the edge (ignored when empty)
//     deq_data   current head entry (valid when !empty)
//     count      number of stored entries, 0..DEPTH
//     empty      count == 0
//   DEPTH must be a power of two >= 2 so the pointers wrap naturally.
// ----------------------------------------------------------------------------
module fetch_queue
    import fetch_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          enq,
    input  fetch_entry_t  enq_data,
    input  logic          deq,
    output fetch_entry_t  deq_data,
    output logic [CW-1:0] count,
    output logic          empty
);

    localparam int PW = $clog2(DEPTH);

    fetch_entry_t  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_enq, do_deq;

    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path leaves one unassigned and no latch is inferred.
        do_enq   = enq && !flush;
        do_deq   = deq && !flush && (count_q != '0);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_enq) wr_ptr_d = wr_ptr_q + PW'(1);
            if (do_deq) rd_ptr_d = rd_ptr_q + PW'(1);
            count_d = count_q + CW'(do_enq) - CW'(do_deq);
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: the storage array has no reset; the pointers and count alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (do_enq) mem_q[wr_ptr_q] <= enq_data;
    end

    assign deq_data = mem_q[rd_ptr_q];
    assign count    = count_q;
    assign empty    = (count_q == '0);

    // The fetch stage's credit scheme means a push never meets a full queue
    // unless the same edge also pops.
    assert property (@(posedge clk) disable iff (rst || flush)
                     (enq && !deq) |-> (count_q < CW'(DEPTH)));

endmodule

// File: rtl/fetch_stage.sv
// ----------------------------------------------------------------------------
// fetch_stage
//   Instruction fetch front end: holds the PC, issues aligned 32-bit reads
//   on a fixed 1-cycle-latency memory port, and buffers {pc, inst} pairs in
//   fetch_queue for decode. A redirect loads a new PC and flushes both the
//   queue and any read still in flight.
//   Ports:
//     clk, rst        clock, synchronous active-high reset
//     imem_addr       read address (word aligned)
//     imem_rmask      4'hF when a read is issued this cycle, else 4'h0
//     imem_rdata      read data, valid with imem_resp
//     imem_resp       response to the read issued the previous cycle
//     redirect_valid  load redirect_pc and flush this cycle
//     redirect_pc     redirect target; bits [1:0] are ignored
//     deq_ready       decode accepts the head entry
//     deq_valid       head entry present
//     deq_pc          PC of the head instruction
//     deq_inst        head instruction word
// ----------------------------------------------------------------------------
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = DEFAULT_RESET_PC,
    parameter int          QUEUE_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    output logic [3:0]  imem_rmask,
    input  logic [31:0] imem_rdata,
    input  logic        imem_resp,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        deq_ready,
    output logic        deq_valid,
    output logic [31:0] deq_pc,
    output logic [31:0] deq_inst
);

    localparam int          CW      = $clog2(QUEUE_DEPTH + 1);
    localparam logic [CW:0] CREDITS = (CW + 1)'(QUEUE_DEPTH);

    logic [31:0]   pc_q, pc_d;
    logic          inflight_q, inflight_d;
    logic [31:0]   inflight_pc_q, inflight_pc_d;

    logic [CW-1:0] q_count;
    logic          q_empty;
    logic [CW:0]   credit_used;
    logic          issue;
    logic          enq;
    logic          deq;
    fetch_entry_t  enq_data;
    fetch_entry_t  deq_data;

    always_comb begin
        // Queue slots plus the read in flight are the credits in use; issuing
        // only while one is free means a response always finds room.
        credit_used = {1'b0, q_count} + {{CW{1'b0}}, inflight_q};
        issue       = !rst && !redirect_valid && (credit_used < CREDITS);

        pc_d          = pc_q;
        inflight_d    = issue;
        inflight_pc_d = inflight_pc_q;
        if (redirect_valid) begin
            pc_d = {redirect_pc[31:2], 2'b00};
        end else if (issue) begin
            pc_d          = pc_q + 32'd4;
            inflight_pc_d = pc_q;
        end

        // A response landing in a redirect cycle belongs to the old stream.
        enq      = imem_resp && inflight_q && !redirect_valid;
        enq_data = '{pc: inflight_pc_q, inst: imem_rdata};
        deq      = !q_empty && deq_ready && !redirect_valid;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    fetch_queue #(
        .DEPTH (QUEUE_DEPTH)
    ) u_queue (
        .clk      (clk),
        .rst      (rst),
        .flush    (redirect_valid),
        .enq      (enq),
        .enq_data (enq_data),
        .deq      (deq),
        .deq_data (deq_data),
        .count    (q_count),
        .empty    (q_empty)
    );

    assign imem_addr  = pc_q;
    assign imem_rmask = issue ? 4'hF : 4'h0;
    assign deq_valid  = !q_empty;
    assign deq_pc     = deq_data.pc;
    assign deq_inst   = deq_data.inst;

    // The memory answers only reads that were issued; anything else is a
    // protocol error on the memory side.
    assert property (@(posedge clk) disable iff (rst) imem_resp |-> inflight_q);

endmodule

// File: tb/tb_fetch_stage.sv
// ----------------------------------------------------------------------------
// tb_fetch_stage
//   Self-checking bench for fetch_stage: a directed per-cycle vector table
//   (reset, streaming, back-pressure, redirects, PC wrap) followed by a
//   randomized run against a stream-level reference model. A 1-cycle magic
//   memory answers every read.
// ----------------------------------------------------------------------------
module tb_fetch_stage;

    localparam logic [31:0] B     = 32'h1eceb000;
    localparam int          DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] imem_addr;
    logic [3:0]  imem_rmask;
    logic [31:0] imem_rdata;
    logic        imem_resp;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        deq_ready;
    logic        deq_valid;
    logic [31:0] deq_pc;
    logic [31:0] deq_inst;

    int n_cmp = 0;
    int n_bad = 0;

    fetch_stage #(
        .RESET_PC    (B),
        .QUEUE_DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_rmask     (imem_rmask),
        .imem_rdata     (imem_rdata),
        .imem_resp      (imem_resp),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .deq_ready      (deq_ready),
        .deq_valid      (deq_valid),
        .deq_pc         (deq_pc),
        .deq_inst       (deq_inst)
    );

    always #5 clk = ~clk;

    // Instruction word stored at each address: distinct for every word.
    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return {addr[15:0], addr[31:16]} ^ 32'h5a3c96e1;
    endfunction

    // Magic memory: answers the read seen at this edge one cycle later;
    // garbage data when no read was issued.
    always @(posedge clk) begin
        imem_resp  <= (imem_rmask == 4'hF);
        imem_rdata <= (imem_rmask == 4'hF) ? mem_word(imem_addr) : $urandom;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        rst;
        logic        rv;
        logic [31:0] rpc;
        logic        rdy;
        logic        exp_issue;
        logic [31:0] exp_addr;
        logic        chk_deq;
        logic        exp_dv;
        logic [31:0] exp_dpc;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(input logic r, input logic rv, input logic [31:0] rpc,
                               input logic rdy, input logic iss, input logic [31:0] addr,
                               input logic chk, input logic dv, input logic [31:0] dpc);
        vec_t t;
        t.rst = r; t.rv = rv; t.rpc = rpc; t.rdy = rdy;
        t.exp_issue = iss; t.exp_addr = addr;
        t.chk_deq = chk; t.exp_dv = dv; t.exp_dpc = dpc;
        return t;
    endfunction

    // Compare the outputs for the current cycle against expectations.
    task automatic check_outputs(input string tag, input logic iss, input logic [31:0] addr,
                                 input logic chk, input logic dv, input logic [31:0] dpc);
        check({tag, " rmask"}, {28'b0, imem_rmask}, iss ? 32'hF : 32'h0);
        if (iss) check({tag, " addr"}, imem_addr, addr);
        if (chk) begin
            check({tag, " deq_valid"}, {31'b0, deq_valid}, {31'b0, dv});
            if (dv) begin
                check({tag, " deq_pc"}, deq_pc, dpc);
                check({tag, " deq_inst"}, deq_inst, mem_word(dpc));
            end
        end
    endtask

    // Stream-level reference model state for the random run.
    logic [31:0] next_issue_pc;
    logic [31:0] next_deq_pc;
    int          outstanding;
    bit          issued_last;

    initial begin
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        deq_ready      = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // ---- Directed per-cycle table ----
        // Streaming after reset with decode always ready.
        vecs.push_back(v(1, 0, 0, 1, 0, 0,        1, 0, 0));
        vecs.push_back(v(0, 0, 0, 1, 1, B,        1, 0, 0));
        vecs.push_back(v(0, 0, 0, 1, 1, B + 4,    1, 0, 0));
        vecs.push_back(v(0, 0, 0, 1, 1, B + 8,    1, 1, B));
        vecs.push_back(v(0, 0, 0, 1, 1, B + 12,   1, 1, B + 4));
        vecs.push_back(v(0, 0, 0, 1, 1, B + 16,   1, 1, B + 8));
        // Reset mid-operation, then decode stalled: exactly four reads.
        vecs.push_back(v(1, 0, 0, 0, 0, 0,        0, 0, 0));
        vecs.push_back(v(1, 0, 0, 0, 0, 0,        1, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 1, B,        1, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 1, B + 4,    1, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 1, B + 8,    1, 1, B));
        vecs.push_back(v(0, 0, 0, 0, 1, B + 12,   1, 1, B));
        vecs.push_back(v(0, 0, 0, 0, 0, 0,        1, 1, B));
        vecs.push_back(v(0, 0, 0, 0, 0, 0,        1, 1, B));
        vecs.push_back(v(0, 0, 0, 0, 0, 0,        1, 1, B));
        // Decode resumes: fetch restarts at B+0x10.
        vecs.push_back(v(0, 0, 0, 1, 0, 0,        1, 1, B));
        vecs.push_back(v(0, 0, 0, 1, 1, B + 16,   1, 1, B + 4));
        vecs.push_back(v(0, 0, 0, 1, 1, B + 20,   1, 1, B + 8));
        vecs.push_back(v(0, 0, 0, 1, 1, B + 24,   1, 1, B + 12));
        vecs.push_back(v(0, 0, 0, 1, 1, B + 28,   1, 1, B + 16));
        // Queue fills to three, then redirect to an unaligned target while the
        // response for B+0x20 is arriving.
        vecs.push_back(v(0, 0, 0, 0, 1, B + 32,   1, 1, B + 20));
        vecs.push_back(v(0, 1, 32'h1eceb103, 0, 0, 0, 1, 1, B + 20));
        vecs.push_back(v(0, 0, 0, 1, 1, 32'h1eceb100, 1, 0, 0));
        vecs.push_back(v(0, 0, 0, 1, 1, 32'h1eceb104, 1, 0, 0));
        vecs.push_back(v(0, 0, 0, 1, 1, 32'h1eceb108, 1, 1, 32'h1eceb100));
        // Back-to-back redirects: only the second stream survives.
        vecs.push_back(v(0, 1, 32'h00002000, 1, 0, 0, 1, 1, 32'h1eceb104));
        vecs.push_back(v(0, 1, 32'h00003002, 1, 0, 0, 1, 0, 0));
        vecs.push_back(v(0, 0, 0, 1, 1, 32'h00003000, 1, 0, 0));
        vecs.push_back(v(0, 0, 0, 1, 1, 32'h00003004, 1, 0, 0));
        vecs.push_back(v(0, 0, 0, 1, 1, 32'h00003008, 1, 1, 32'h00003000));
        // Redirect to the top of the address space: PC wraps to zero.
        vecs.push_back(v(0, 1, 32'hFFFFFFFC, 1, 0, 0, 1, 1, 32'h00003004));
        vecs.push_back(v(0, 0, 0, 1, 1, 32'hFFFFFFFC, 1, 0, 0));
        vecs.push_back(v(0, 0, 0, 1, 1, 32'h00000000, 1, 0, 0));
        vecs.push_back(v(0, 0, 0, 1, 1, 32'h00000004, 1, 1, 32'hFFFFFFFC));
        vecs.push_back(v(0, 0, 0, 1, 1, 32'h00000008, 1, 1, 32'h00000000));

        for (int i = 0; i < vecs.size(); i++) begin
            rst            = vecs[i].rst;
            redirect_valid = vecs[i].rv;
            redirect_pc    = vecs[i].rpc;
            deq_ready      = vecs[i].rdy;
            #2;
            check_outputs($sformatf("row%0d", i), vecs[i].exp_issue, vecs[i].exp_addr,
                          vecs[i].chk_deq, vecs[i].exp_dv, vecs[i].exp_dpc);
            @(posedge clk);
            #1;
        end

        // ---- Randomized run against the stream model ----
        rst            = 1'b1;
        redirect_valid = 1'b0;
        deq_ready      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst           = 1'b0;
        next_issue_pc = B;
        next_deq_pc   = B;
        outstanding   = 0;
        issued_last   = 1'b0;

        for (int cyc = 0; cyc < 3000; cyc++) begin
            bit          exp_issue;
            bit          exp_dv;
            bit          pop;
            int unsigned thresh;
            thresh         = ((cyc / 64) % 2 == 0) ? 85 : 25;
            redirect_valid = ($urandom_range(0, 9) == 0);
            redirect_pc    = ($urandom_range(0, 3) == 0) ? (32'hFFFFFFF0 | 32'($urandom_range(0, 15)))
                                                         : $urandom;
            deq_ready      = ($urandom_range(0, 99) < thresh);
            #2;

            // Requests issued but not yet consumed may never exceed the queue
            // depth; entries become visible two cycles after their request.
            exp_issue = !redirect_valid && (outstanding < DEPTH);
            exp_dv    = (outstanding - int'(issued_last)) > 0;
            pop       = exp_dv && deq_ready && !redirect_valid;

            check_outputs($sformatf("rnd%0d", cyc), exp_issue, next_issue_pc,
                          1'b1, exp_dv, next_deq_pc);

            if (redirect_valid) begin
                next_issue_pc = {redirect_pc[31:2], 2'b00};
                next_deq_pc   = {redirect_pc[31:2], 2'b00};
                outstanding   = 0;
                issued_last   = 1'b0;
            end else begin
                if (exp_issue) begin
                    outstanding++;
                    next_issue_pc = next_issue_pc + 32'd4;
                end
                if (pop) begin
                    outstanding--;
                    next_deq_pc = next_deq_pc + 32'd4;
                end
                issued_last = exp_issue;
            end
            @(posedge clk);
            #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
